fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter PC_RESET, default 32'h0000_3000, fetch PC after reset.
REQ-002 SHALL provide parameter IM_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-003 SHALL provide parameter IM_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-006 SHALL have port stall  input  1  hazard stall from the hazard unit; holds the PC and the F/D register.
REQ-007 SHALL have port npc_sel  input  3  next-PC select from the D-stage decoder: 000 sequential, 001 branch, 010 j/jal, 100 jr/jalr.
REQ-008 SHALL have port br_taken  input  1  branch condition evaluated in D (beq/bgtz).
REQ-009 SHALL have port imm16  input  16  D-stage Imm16 field.
REQ-010 SHALL have port imm26  input  26  D-stage Imm26 field.
REQ-011 SHALL have port rs_val  input  32  forwarded GPR[rs] for jr/jalr.
REQ-012 SHALL have port im_rdata  input  32  instruction word returned combinationally by the instruction memory for im_addr.
REQ-013 SHALL have port im_addr  output  32  current fetch PC (F_PC) driven to the instruction memory.
REQ-014 SHALL have port D_instr  output  32  registered instruction delivered to the D stage.
REQ-015 SHALL have port D_pc  output  32  registered PC of D_instr.
REQ-016 SHALL have port D_pc8  output  32  D_pc+8, the link address for jal/jalr.
REQ-017 SHALL have port D_exc_adel  output  1  registered flag: D_instr was replaced because its fetch address was illegal.

Function
REQ-018 SHALL hold F_PC in a 32-bit register; im_addr = F_PC, combinationally.
REQ-019 SHALL compute the branch target as D_pc + 4 + (sign_extend(imm16) << 2), with the 32-bit sum wrapping modulo 2^32.
REQ-020 SHALL compute the jump target as {D_pc[31:28], imm26, 2'b00}.
REQ-021 SHALL compute the jr target as rs_val, passed through unmodified.
REQ-022 SHALL compute the next PC as: branch target if npc_sel==001 and br_taken; jump target if npc_sel==010; rs_val if npc_sel==100; otherwise F_PC+4, including npc_sel==001 with br_taken==0 and every undefined npc_sel code.
REQ-023 SHALL implement one architectural delay slot: the instruction in F while a branch/jump is in D is always loaded into F/D and never squashed.
REQ-024 SHALL, at a rising edge with reset==1 and stall==0, load F_PC with the next PC and load the F/D register from the F stage.
REQ-025 SHALL, at a rising edge with reset==1 and stall==1, hold F_PC, D_instr, D_pc and D_exc_adel unchanged; any redirect present that cycle is ignored and is re-evaluated the next cycle.
REQ-026 SHALL treat F_PC as illegal when F_PC[1:0] != 0, F_PC < IM_LO, or F_PC > IM_HI.
REQ-027 SHALL, when an F-stage address is illegal, load D_instr with 32'h0000_0000 (nop) and D_exc_adel with 1, load D_pc with the illegal F_PC, and SHALL NOT consume im_rdata.
REQ-028 SHALL, when the F-stage address is legal, load D_instr with im_rdata and D_exc_adel with 0.
REQ-029 SHALL continue sequencing from an illegal F_PC by the normal next-PC rule; the block SHALL NOT halt.
REQ-030 SHALL derive D_pc8 combinationally as D_pc + 32'd8, wrapping modulo 2^32.
REQ-031 SHALL have a latency of exactly one cycle from F_PC to the corresponding D_instr/D_pc outputs when stall==0.

Reset
REQ-032 SHALL, at a rising edge with reset==0, set F_PC=PC_RESET, D_instr=0, D_pc=PC_RESET, D_exc_adel=0.
REQ-033 SHALL give reset priority over stall and npc_sel at the same edge.
REQ-034 SHALL, when reset asserts mid-operation (e.g. a branch in D), discard the pending redirect and restart fetch at PC_RESET on the next cycle.
REQ-035 SHALL leave all state unchanged while reset==0 between clock edges; no asynchronous effect.

Verification
REQ-036 SHALL verify reset: reset=0 for 2 cycles with stall=1, npc_sel=010 -> F_PC=0x3000, D_instr=0, D_pc=0x3000, D_exc_adel=0; first fetch after release is 0x3000.
REQ-037 SHALL verify sequential fetch: IM returns 0x11+addr -> D_pc=0x3000, 0x3004, 0x3008 on successive cycles, each D_instr matching its D_pc, and D_pc8 = D_pc+8.
REQ-038 SHALL verify a taken branch with delay slot: D_pc=0x3004, npc_sel=001, br_taken=1, imm16=0xFFFF -> delay-slot instruction 0x3008 enters D, then F_PC=0x3004.
REQ-039 SHALL verify stall: stall=1 for 3 cycles at F_PC=0x3010 with npc_sel=010 -> F_PC and D_* unchanged; on release the jump target is taken.
REQ-040 SHALL verify an illegal jr target: npc_sel=100, rs_val=0x3001 -> next cycle D_instr=0, D_exc_adel=1, D_pc=0x3001; then F_PC=0x3005, also flagged.
REQ-041 SHALL verify a jump with wrap and range: D_pc=0x3000, npc_sel=010, imm26=0x3FFFFFF -> F_PC=0x0FFFFFFC, flagged illegal (above IM_HI).

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with one architectural delay slot. It holds the
//   fetch PC (F_PC), presents it to the instruction memory, and captures the
//   returned instruction into the F/D pipeline register. It selects the next
//   PC from the redirect requested by the D stage (branch / jump / jr).
//   Fetch addresses that are misaligned or outside [IM_LO, IM_HI] are not
//   read. A nop with an address-error flag is sent down the pipe instead.
//
// Parameters
//   PC_RESET   : fetch PC loaded by reset
//   IM_LO      : lowest legal fetch address
//   IM_HI      : highest legal fetch address
//
// Ports
//   clk        : in   clock, rising edge
//   reset      : in   synchronous, active-low reset
//   stall      : in   hold F_PC and the F/D register
//   npc_sel    : in   [2:0] next-PC select (000 seq, 001 br, 010 j, 100 jr)
//   br_taken   : in   branch condition evaluated in D
//   imm16      : in   [15:0] branch offset field of D_instr
//   imm26      : in   [25:0] jump index field of D_instr
//   rs_val     : in   [31:0] forwarded GPR[rs] for jr/jalr
//   im_rdata   : in   [31:0] instruction word at im_addr
//   im_addr    : out  [31:0] current fetch PC
//   D_instr    : out  [31:0] instruction in D
//   D_pc       : out  [31:0] PC of D_instr
//   D_pc8      : out  [31:0] D_pc + 8 (link address)
//   D_exc_adel : out  D_instr was replaced due to an illegal fetch address
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic        D_exc_adel
);

    localparam logic [2:0]  SEL_BRANCH = 3'b001;
    localparam logic [2:0]  SEL_JUMP   = 3'b010;
    localparam logic [2:0]  SEL_JR     = 3'b100;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    // An address is fetchable only when word aligned and inside the IM window.
    function automatic logic addr_illegal(input logic [31:0] addr);
        logic bad_v;
        bad_v = 1'b0;
        if (addr[1:0] != 2'b00) begin
            bad_v = 1'b1;
        end else if ((addr < IM_LO) || (addr > IM_HI)) begin
            bad_v = 1'b1;
        end else begin
            bad_v = 1'b0;
        end
        return bad_v;
    endfunction

    logic [31:0] f_pc_r;
    logic [31:0] d_instr_r;
    logic [31:0] d_pc_r;
    logic [31:0] d_pc8_r;
    logic        d_exc_adel_r;

    logic [31:0] seq_pc_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;
    logic [31:0] npc_s;
    logic        f_illegal_s;
    logic [31:0] f_instr_s;

    // Redirect targets; every sum wraps modulo 2^32.
    always_comb begin
        seq_pc_s    = f_pc_r + 32'd4;
        br_target_s = d_pc_r + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_target_s  = {d_pc_r[31:28], imm26, 2'b00};
    end

    // Next-PC select; an untaken branch and any undefined code fall through to sequential.
    always_comb begin
        npc_s = seq_pc_s;
        case (npc_sel)
            SEL_BRANCH: begin
                if (br_taken) begin
                    npc_s = br_target_s;
                end else begin
                    npc_s = seq_pc_s;
                end
            end
            SEL_JUMP:   npc_s = j_target_s;
            SEL_JR:     npc_s = rs_val;
            default:    npc_s = seq_pc_s;
        endcase
    end

    // Illegal fetches never consume the memory word; a nop is substituted.
    always_comb begin
        f_illegal_s = addr_illegal(f_pc_r);
        if (f_illegal_s) begin
            f_instr_s = NOP_INSTR;
        end else begin
            f_instr_s = im_rdata;
        end
    end

    // PC and F/D register: reset beats stall, stall freezes everything (delay slot is never squashed).
    always_ff @(posedge clk) begin
        if (!reset) begin
            f_pc_r       <= PC_RESET;
            d_instr_r    <= NOP_INSTR;
            d_pc_r       <= PC_RESET;
            d_pc8_r      <= PC_RESET + 32'd8;
            d_exc_adel_r <= 1'b0;
        end else if (!stall) begin
            f_pc_r       <= npc_s;
            d_instr_r    <= f_instr_s;
            d_pc_r       <= f_pc_r;
            d_pc8_r      <= f_pc_r + 32'd8;
            d_exc_adel_r <= f_illegal_s;
        end else begin
            f_pc_r       <= f_pc_r;
            d_instr_r    <= d_instr_r;
            d_pc_r       <= d_pc_r;
            d_pc8_r      <= d_pc8_r;
            d_exc_adel_r <= d_exc_adel_r;
        end
    end

    assign im_addr    = f_pc_r;
    assign D_instr    = d_instr_r;
    assign D_pc       = d_pc_r;
    assign D_pc8      = d_pc8_r;
    assign D_exc_adel = d_exc_adel_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed vector table for the fetch stage followed by randomized traffic
//   checked against a behavioural model. The instruction memory model returns
//   address + 0x11 for every address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic [31:0] im_rdata;
    logic [31:0] im_addr;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic        D_exc_adel;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .br_taken   (br_taken),
        .imm16      (imm16),
        .imm26      (imm26),
        .rs_val     (rs_val),
        .im_rdata   (im_rdata),
        .im_addr    (im_addr),
        .D_instr    (D_instr),
        .D_pc       (D_pc),
        .D_pc8      (D_pc8),
        .D_exc_adel (D_exc_adel)
    );

    // Instruction memory: word content is its address plus 0x11.
    assign im_rdata = im_addr + 32'h0000_0011;

    // Clock: period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stl;
        logic [2:0]  sel;
        logic        br;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic [31:0] e_fpc;
        logic [31:0] e_dpc;
        logic [31:0] e_instr;
        logic        e_exc;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl[NVEC];

    // Behavioural reference state.
    logic [31:0] m_fpc, m_dpc, m_instr;
    logic        m_exc;

    function automatic logic legal(input logic [31:0] a);
        return ((a % 32'd4) == 32'd0) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic [31:0] nxt;
        if (reset == 1'b0) begin
            m_fpc = 32'h0000_3000; m_dpc = 32'h0000_3000; m_instr = 32'h0; m_exc = 1'b0;
        end else if (stall == 1'b0) begin
            if (npc_sel == 3'b001 && br_taken)
                nxt = m_dpc + 32'd4 + 32'(int'($signed(imm16)) * 4);
            else if (npc_sel == 3'b010)
                nxt = (m_dpc & 32'hF000_0000) | (32'(imm26) * 32'd4);
            else if (npc_sel == 3'b100)
                nxt = rs_val;
            else
                nxt = m_fpc + 32'd4;
            m_dpc   = m_fpc;
            m_exc   = !legal(m_fpc);
            m_instr = legal(m_fpc) ? (m_fpc + 32'h11) : 32'h0;
            m_fpc   = nxt;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [2:0] sel, input logic b,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        reset = r; stall = s; npc_sel = sel; br_taken = b; imm16 = i16; imm26 = i26; rs_val = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b1; npc_sel = 3'b010; br_taken = 1'b0;
        imm16 = 16'h0; imm26 = 26'h0; rs_val = 32'h0;
        m_fpc = 32'h0; m_dpc = 32'h0; m_instr = 32'h0; m_exc = 1'b0;

        //          rst   stl   sel     br    imm16     imm26         rs_val        fpc           dpc           instr         exc
        tbl[0]  = '{1'b0, 1'b1, 3'b010, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3000, 32'h0000_3000, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'b010, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3000, 32'h0000_3000, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3004, 32'h0000_3000, 32'h0000_3011, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3008, 32'h0000_3004, 32'h0000_3015, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 1'b1, 16'hFFFF, 26'h0000000, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008, 32'h0000_3019, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3008, 32'h0000_3004, 32'h0000_3015, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_300C, 32'h0000_3008, 32'h0000_3019, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3010, 32'h0000_300C, 32'h0000_301D, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'b010, 1'b0, 16'h0000, 26'h0000C10, 32'h0000_0000, 32'h0000_3010, 32'h0000_300C, 32'h0000_301D, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'b010, 1'b0, 16'h0000, 26'h0000C10, 32'h0000_0000, 32'h0000_3010, 32'h0000_300C, 32'h0000_301D, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 3'b010, 1'b0, 16'h0000, 26'h0000C10, 32'h0000_0000, 32'h0000_3010, 32'h0000_300C, 32'h0000_301D, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'b010, 1'b0, 16'h0000, 26'h0000C10, 32'h0000_0000, 32'h0000_3040, 32'h0000_3010, 32'h0000_3021, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'b100, 1'b0, 16'h0000, 26'h0000000, 32'h0000_3001, 32'h0000_3001, 32'h0000_3040, 32'h0000_3051, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3005, 32'h0000_3001, 32'h0000_0000, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3009, 32'h0000_3005, 32'h0000_0000, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 3'b100, 1'b0, 16'h0000, 26'h0000000, 32'h0000_3001, 32'h0000_3000, 32'h0000_3000, 32'h0000_0000, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 3'b010, 1'b0, 16'h0000, 26'h3FFFFFF, 32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_3000, 32'h0000_3011, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h1000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h1000_0004, 32'h1000_0000, 32'h0000_0000, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 3'b001, 1'b0, 16'h0040, 26'h0000000, 32'h0000_0000, 32'h1000_0008, 32'h1000_0004, 32'h0000_0000, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 3'b111, 1'b1, 16'h0040, 26'h0000040, 32'h0000_3000, 32'h1000_000C, 32'h1000_0008, 32'h0000_0000, 1'b1};
        tbl[21] = '{1'b1, 1'b0, 3'b100, 1'b0, 16'h0000, 26'h0000000, 32'h0000_6FFC, 32'h0000_6FFC, 32'h1000_000C, 32'h0000_0000, 1'b1};
        tbl[22] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_7000, 32'h0000_6FFC, 32'h0000_700D, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_7004, 32'h0000_7000, 32'h0000_0000, 1'b1};
        tbl[24] = '{1'b1, 1'b0, 3'b100, 1'b0, 16'h0000, 26'h0000000, 32'h0000_2FFC, 32'h0000_2FFC, 32'h0000_7004, 32'h0000_0000, 1'b1};
        tbl[25] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3000, 32'h0000_2FFC, 32'h0000_0000, 1'b1};
        tbl[26] = '{1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000, 32'h0000_3004, 32'h0000_3000, 32'h0000_3011, 1'b0};

        @(negedge clk);
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].sel, tbl[i].br, tbl[i].i16, tbl[i].i26, tbl[i].rs);
            chk($sformatf("v%0d im_addr", i), im_addr, tbl[i].e_fpc);
            chk($sformatf("v%0d D_pc", i), D_pc, tbl[i].e_dpc);
            chk($sformatf("v%0d D_instr", i), D_instr, tbl[i].e_instr);
            chk($sformatf("v%0d D_pc8", i), D_pc8, tbl[i].e_dpc + 32'd8);
            chk($sformatf("v%0d D_exc_adel", i), {31'd0, D_exc_adel}, {31'd0, tbl[i].e_exc});
            if (i == 3) begin
                // Reset pulse between edges must have no effect.
                reset = 1'b0;
                #2;
                chk("async_reset im_addr", im_addr, 32'h0000_3008);
                chk("async_reset D_pc", D_pc, 32'h0000_3004);
                reset = 1'b1;
            end
        end

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            logic        r_v, s_v, b_v;
            logic [2:0]  sel_v;
            logic [25:0] i26_v;
            logic [31:0] rs_v;
            r_v   = ($urandom_range(0, 31) != 0);
            s_v   = ($urandom_range(0, 3) == 0);
            sel_v = 3'($urandom_range(0, 7));
            b_v   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) i26_v = 26'($urandom);
            else i26_v = 26'($urandom_range(32'h0C00, 32'h1BFF));
            if ($urandom_range(0, 3) == 0) rs_v = $urandom;
            else rs_v = 32'($urandom_range(32'h2FF0, 32'h7010));
            drive(r_v, s_v, sel_v, b_v, 16'($urandom), i26_v, rs_v);
            chk("rnd im_addr", im_addr, m_fpc);
            chk("rnd D_pc", D_pc, m_dpc);
            chk("rnd D_instr", D_instr, m_instr);
            chk("rnd D_pc8", D_pc8, m_dpc + 32'd8);
            chk("rnd D_exc_adel", {31'd0, D_exc_adel}, {31'd0, m_exc});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
